// File: rtl/ram_bist_ctrl_pkg.sv
// ram_bist_ctrl_pkg
//   Shared definitions for the RAM BIST controller: FSM state encoding.
//   No ports; imported by ram_bist_ctrl.
package ram_bist_ctrl_pkg;

  // March sequencer states. DRAIN waits out the RAM read latency after the
  // last read address so that every readback word is compared.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_bist_ctrl_rdpipe.sv
// ram_bist_ctrl_rdpipe
//   RD_LAT-stage shift register carrying (valid, addr, expected) alongside the
//   RAM read pipeline, so the stage output lines up with douta.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears valid)
//   in_valid/addr/exp     entry pushed on every clock edge
//   out_valid/addr/exp    entry pushed RD_LAT edges earlier
module ram_bist_ctrl_rdpipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];
  logic [DATA_W-1:0] exp_q [RD_LAT];

  // Delay line shift; reset empties it so no stale compare fires later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        adr[i]   <= '0;
        exp_q[i] <= '0;
      end
    end else begin
      vld[0]   <= in_valid;
      adr[0]   <= in_addr;
      exp_q[0] <= in_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i]   <= vld[i-1];
        adr[i]   <= adr[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_addr  = adr[RD_LAT-1];
  assign out_exp   = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//   Two-pass write/readback march BIST over a single-port RAM. Pass 0 writes
//   seed+addr, pass 1 writes ~(seed+addr); every word is read back and compared.
// Ports:
//   clka, rsta           clock, synchronous active-high reset
//   start, seed          run request (accepted in IDLE/DONE) and pattern base
//   mem_addra/dina/wea   RAM command port, owned by this block while busy
//   mem_douta            RAM read data, valid RD_LAT cycles after the address
//   busy, done, pass     run status; pass valid while done
//   err_count            saturating mismatch count over both passes
//   first_err_addr/pass  location of the first mismatch (0 if none)
module ram_bist_ctrl
  import ram_bist_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic              mem_wea,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_pass
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              phase;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic              start_ok;
  logic              addr_last;
  logic              drain_last;
  logic              pv;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pexp;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a,
                                                input logic              p);
    logic [DATA_W-1:0] sum;
    sum = s + DATA_W'(a);
    return p ? ~sum : sum;
  endfunction

  // busy also covers the one result-registration cycle spent in DONE, so a
  // start there is still ignored.
  assign start_ok   = start && !busy && ((state == ST_IDLE) || (state == ST_DONE));
  assign addr_last  = (addr == ADDR_LAST);
  assign drain_last = (lat_cnt == LAT_LAST);
  assign pat        = pattern(seed_q, addr, phase);
  assign mismatch   = pv && (mem_douta != pexp);

  // State register.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and RAM command decode.
  always_comb begin
    state_nxt = state;
    mem_wea   = 1'b0;
    mem_addra = addr;
    mem_dina  = '0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_WRITE;
        else          state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        mem_wea  = 1'b1;
        mem_dina = pat;
        if (addr_last) state_nxt = ST_READ;
        else           state_nxt = ST_WRITE;
      end
      ST_READ: begin
        if (addr_last) state_nxt = ST_DRAIN;
        else           state_nxt = ST_READ;
      end
      ST_DRAIN: begin
        if (drain_last) state_nxt = phase ? ST_DONE : ST_WRITE;
        else            state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (start_ok) state_nxt = ST_WRITE;
        else          state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/phase/drain counters and run status.
  always_ff @(posedge clka) begin
    if (rsta) begin
      addr    <= '0;
      phase   <= 1'b0;
      lat_cnt <= 3'd0;
      seed_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (start_ok) begin
      addr    <= '0;
      phase   <= 1'b0;
      lat_cnt <= 3'd0;
      seed_q  <= seed;
      busy    <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        // DEPTH is a power of two, so the increment wraps to 0 exactly at
        // the phase change.
        ST_WRITE, ST_READ: addr <= addr + 1'b1;
        ST_DRAIN: begin
          lat_cnt <= drain_last ? 3'd0 : lat_cnt + 3'd1;
          if (drain_last) phase <= 1'b1;
        end
        // Last compare landed on the edge that entered DONE; publish now.
        ST_DONE: begin
          if (busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Error bookkeeping: saturating count, first-failure location.
  always_ff @(posedge clka) begin
    if (rsta || start_ok) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_pass <= 1'b0;
    end else if (mismatch) begin
      if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
      if (err_count == '0) begin
        first_err_addr <= paddr;
        first_err_pass <= phase;
      end
    end
  end

  ram_bist_ctrl_rdpipe #(
    .RD_LAT(RD_LAT),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rdpipe (
    .clk      (clka),
    .rst      (rsta),
    .in_valid (state == ST_READ),
    .in_addr  (addr),
    .in_exp   (pat),
    .out_valid(pv),
    .out_addr (paddr),
    .out_exp  (pexp)
  );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
//   Directed bench: two controllers (RD_LAT=1 and RD_LAT=2) each driving a
//   behavioural RAM with injectable stuck-at faults.
module tb_ram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rsta;
  logic        start, start_b;
  logic [31:0] seed, seed_b;

  logic [5:0]  addra, addra_b;
  logic [31:0] dina, dina_b, douta, douta_b;
  logic        wea, wea_b;
  logic        busy, done, pass, busy_b, done_b, pass_b;
  logic [7:0]  errc, errc_b;
  logic [5:0]  fea, fea_b;
  logic        fep, fep_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned tick     = 0;
  int unsigned t_start;

  // Fault controls: model A stuck-at-0 mask, model B stuck-at-1 mask.
  logic [5:0]  fa_addr = 6'd0;
  logic [31:0] fa_clr  = 32'h0;
  logic [5:0]  fb_addr = 6'd0;
  logic [31:0] fb_set  = 32'h0;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] rda, rdb1, rdb2;

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  // Latency-1 RAM model.
  always @(posedge clk) begin
    if (wea) mem_a[addra] <= (addra == fa_addr) ? (dina & ~fa_clr) : dina;
    rda <= mem_a[addra];
  end
  assign douta = rda;

  // Latency-2 RAM model.
  always @(posedge clk) begin
    if (wea_b) mem_b[addra_b] <= (addra_b == fb_addr) ? (dina_b | fb_set) : dina_b;
    rdb1 <= mem_b[addra_b];
    rdb2 <= rdb1;
  end
  assign douta_b = rdb2;

  ram_bist_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(1), .ERR_W(8)) dut (
    .clka(clk), .rsta(rsta), .start(start), .seed(seed),
    .mem_addra(addra), .mem_dina(dina), .mem_wea(wea), .mem_douta(douta),
    .busy(busy), .done(done), .pass(pass), .err_count(errc),
    .first_err_addr(fea), .first_err_pass(fep)
  );

  ram_bist_ctrl #(.ADDR_W(6), .DATA_W(32), .RD_LAT(2), .ERR_W(8)) dut_b (
    .clka(clk), .rsta(rsta), .start(start_b), .seed(seed_b),
    .mem_addra(addra_b), .mem_dina(dina_b), .mem_wea(wea_b), .mem_douta(douta_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(errc_b),
    .first_err_addr(fea_b), .first_err_pass(fep_b)
  );

  // One-cycle start on dut; returns at the negedge after the accepting edge
  // (tick == t_start there).
  task automatic kick(input logic [31:0] s);
    @(negedge clk);
    start   = 1'b1;
    seed    = s;
    t_start = tick + 1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_tick(input int unsigned n);
    while (tick < t_start + n) @(negedge clk);
  endtask

  // Polls done at negedges; returns edges elapsed from the accepting edge.
  task automatic wait_done(output int unsigned el);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    el = tick - t_start;
  endtask

  task automatic test_reset;
    rsta = 1'b1; start = 1'b0; start_b = 1'b0; seed = '0; seed_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wea, addra, dina, busy, done, pass, errc, fea, fep} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got wea=%b addr=%0d dina=%h busy=%b done=%b pass=%b err=%0d fea=%0d fep=%b want all 0",
               wea, addra, dina, busy, done, pass, errc, fea, fep);
    end
    rsta = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int unsigned el;
    kick(32'h0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hi got %b want 1", busy); end
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (wea !== 1'b1 || addra !== 6'(i) || dina !== 32'(i)) begin
        n_fail++;
        $display("FAIL basic_write[%0d] got wea=%b addr=%0d dina=%h want 1/%0d/%h", i, wea, addra, dina, i, i);
      end
    end
    wait_tick(64);
    n_checks++;
    if (wea !== 1'b0 || addra !== 6'd0) begin
      n_fail++; $display("FAIL basic_read0 got wea=%b addr=%0d want 0/0", wea, addra);
    end
    wait_tick(129);
    n_checks++;
    if (wea !== 1'b1 || addra !== 6'd0 || dina !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL basic_pass1_w0 got wea=%b addr=%0d dina=%h want 1/0/ffffffff", wea, addra, dina);
    end
    wait_tick(258);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_pre_done got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(el);
    n_checks++;
    if (el !== 259) begin n_fail++; $display("FAIL basic_done_time got %0d want 259", el); end
    n_checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || errc !== 8'd0 || fea !== 6'd0 || fep !== 1'b0) begin
      n_fail++; $display("FAIL basic_result got busy=%b pass=%b err=%0d fea=%0d fep=%b want 0/1/0/0/0",
                         busy, pass, errc, fea, fep);
    end
  endtask

  task automatic test_stuck0;
    int unsigned el;
    fa_addr = 6'd5; fa_clr = 32'h1;
    kick(32'h0);
    wait_done(el);
    n_checks++;
    if (errc !== 8'd1 || fea !== 6'd5 || fep !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL stuck0_result got err=%0d fea=%0d fep=%b pass=%b want 1/5/0/0", errc, fea, fep, pass);
    end
    fa_clr = 32'h0;
  endtask

  task automatic test_restart_from_done;
    int unsigned el;
    kick(32'h0000_1000);
    n_checks++;
    if (done !== 1'b0 || errc !== 8'd0 || fea !== 6'd0 || pass !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear got done=%b err=%0d fea=%0d pass=%b busy=%b want 0/0/0/0/1",
                         done, errc, fea, pass, busy);
    end
    wait_done(el);
    n_checks++;
    if (el !== 259 || pass !== 1'b1 || errc !== 8'd0) begin
      n_fail++; $display("FAIL restart_result got t=%0d pass=%b err=%0d want 259/1/0", el, pass, errc);
    end
  endtask

  task automatic test_seed_wrap;
    int unsigned el;
    kick(32'hFFFF_FFFF);
    n_checks++;
    if (dina !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0 got %h want ffffffff", dina); end
    wait_tick(1);
    n_checks++;
    if (wea !== 1'b1 || addra !== 6'd1 || dina !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_addr1 got wea=%b addr=%0d dina=%h want 1/1/00000000", wea, addra, dina);
    end
    wait_done(el);
    n_checks++;
    if (pass !== 1'b1 || errc !== 8'd0) begin
      n_fail++; $display("FAIL wrap_result got pass=%b err=%0d want 1/0", pass, errc);
    end
  endtask

  task automatic test_start_while_busy;
    int unsigned el;
    kick(32'h0000_0040);
    wait_tick(30);
    start = 1'b1; seed = 32'hDEAD_0000;
    @(negedge clk);
    start = 1'b0;
    wait_done(el);
    n_checks++;
    if (el !== 259 || pass !== 1'b1 || errc !== 8'd0) begin
      n_fail++; $display("FAIL busy_start got t=%0d pass=%b err=%0d want 259/1/0", el, pass, errc);
    end
  endtask

  task automatic test_reset_mid_run;
    int unsigned el;
    int guard;
    kick(32'h0000_0007);
    guard = 0;
    while (!(wea === 1'b1 && addra === 6'd20) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (addra !== 6'd20) begin n_fail++; $display("FAIL abort_reach got addr=%0d want 20", addra); end
    rsta = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wea !== 1'b0 || addra !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state got wea=%b addr=%0d busy=%b done=%b want 0/0/0/0", wea, addra, busy, done);
    end
    rsta = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wea !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet got wea=%b busy=%b want 0/0", wea, busy);
    end
    kick(32'h0);
    wait_done(el);
    n_checks++;
    if (el !== 259 || pass !== 1'b1) begin
      n_fail++; $display("FAIL abort_rerun got t=%0d pass=%b want 259/1", el, pass);
    end
  endtask

  task automatic test_lat2_stuck1;
    int unsigned el;
    int guard;
    // seed+63 wraps to 0: pass 0 writes 0 (fails), pass 1 writes all-ones (passes).
    fb_addr = 6'd63; fb_set = 32'hFFFF_FFFF;
    @(negedge clk);
    start_b = 1'b1; seed_b = 32'hFFFF_FFC1;
    t_start = tick + 1;
    @(negedge clk);
    start_b = 1'b0;
    guard = 0;
    while (done_b !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    el = tick - t_start;
    n_checks++;
    if (el !== 261) begin n_fail++; $display("FAIL lat2_done_time got %0d want 261", el); end
    n_checks++;
    if (errc_b !== 8'd1 || fea_b !== 6'd63 || fep_b !== 1'b0 || pass_b !== 1'b0) begin
      n_fail++; $display("FAIL lat2_result got err=%0d fea=%0d fep=%b pass=%b want 1/63/0/0", errc_b, fea_b, fep_b, pass_b);
    end
    fb_set = 32'h0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck0();
    test_restart_from_done();
    test_seed_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    test_lat2_stuck1();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
